// File: rtl/l2_mem_arbiter.sv
// Two-requester arbiter in front of a single L2 memory port.
// A request is granted in IDLE (round-robin on ties), its command is latched and
// presented to memory in BUSY, and the requester gets a one-cycle ready pulse in DONE.
module l2_mem_arbiter #(
  parameter int unsigned TNUM = 21,
  parameter int unsigned INUM = 26 - TNUM
) (
  input  logic                clk,
  input  logic                rstn,
  // Requester side
  input  logic [1:0]          read_req,
  input  logic [1:0]          write_req,
  input  logic [2*TNUM-1:0]   tag_req,
  input  logic [2*INUM-1:0]   index_req,
  input  logic [1023:0]       wdata_req,
  output logic [1:0]          ready_req,
  output logic [511:0]        rdata_req,
  output logic                busy,
  // Memory side
  output logic                read_L2_MEM,
  output logic                write_L2_MEM,
  output logic [TNUM-1:0]     tag_L2_MEM,
  output logic [INUM-1:0]     index_L2_MEM,
  output logic [511:0]        write_data_L2_MEM,
  input  logic                ready_MEM_L2,
  input  logic [511:0]        read_data_MEM_L2
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic              op_write_q, op_write_d;
  logic [TNUM-1:0]   tag_q, tag_d;
  logic [INUM-1:0]   index_q, index_d;
  logic [511:0]      wdata_q, wdata_d;
  logic [511:0]      rdata_q, rdata_d;

  logic [1:0]        pending;
  logic              sel;

  assign pending = read_req | write_req;

  // Pick the requester to grant: the only pending one, or on a tie the one not granted last.
  always_comb begin
    sel = 1'b0;
    if (pending == 2'b11) begin
      sel = ~last_grant_q;
    end else begin
      sel = pending[1];
    end
  end

  // Next-state logic: grant and latch in IDLE, wait for memory in BUSY, pulse ready in DONE.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    op_write_d   = op_write_q;
    tag_d        = tag_q;
    index_d      = index_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (|pending) begin
          state_d      = StBusy;
          grant_d      = sel;
          last_grant_d = sel;
          // Read and write together is a write.
          op_write_d   = sel ? write_req[1] : write_req[0];
          tag_d        = sel ? tag_req[TNUM +: TNUM]   : tag_req[0 +: TNUM];
          index_d      = sel ? index_req[INUM +: INUM] : index_req[0 +: INUM];
          wdata_d      = sel ? wdata_req[512 +: 512]   : wdata_req[0 +: 512];
        end
      end
      StBusy: begin
        if (ready_MEM_L2) begin
          state_d = StDone;
          if (!op_write_q) begin
            rdata_d = read_data_MEM_L2;
          end
        end
      end
      StDone: begin
        // No grant here so the requester can drop its request after seeing ready.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and latched transaction registers; reset clears everything, last_grant to 1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      op_write_q   <= 1'b0;
      tag_q        <= '0;
      index_q      <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      op_write_q   <= op_write_d;
      tag_q        <= tag_d;
      index_q      <= index_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // Outputs decode from registered state only, so reset forces them low at once.
  always_comb begin
    read_L2_MEM       = (state_q == StBusy) && !op_write_q;
    write_L2_MEM      = (state_q == StBusy) && op_write_q;
    tag_L2_MEM        = tag_q;
    index_L2_MEM      = index_q;
    write_data_L2_MEM = wdata_q;
    rdata_req         = rdata_q;
    busy              = (state_q != StIdle);
    ready_req         = 2'b00;
    if (state_q == StDone) begin
      ready_req = grant_q ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Self-checking bench for l2_mem_arbiter: a scoreboard queue of expected grants,
// a table of single transactions and hand-written tie, latch and reset sequences.
module tb_l2_mem_arbiter;

  localparam int unsigned TNUM = 21;
  localparam int unsigned INUM = 5;

  logic                clk = 1'b0;
  logic                rstn;
  logic [1:0]          read_req;
  logic [1:0]          write_req;
  logic [2*TNUM-1:0]   tag_req;
  logic [2*INUM-1:0]   index_req;
  logic [1023:0]       wdata_req;
  logic [1:0]          ready_req;
  logic [511:0]        rdata_req;
  logic                busy;
  logic                read_L2_MEM;
  logic                write_L2_MEM;
  logic [TNUM-1:0]     tag_L2_MEM;
  logic [INUM-1:0]     index_L2_MEM;
  logic [511:0]        write_data_L2_MEM;
  logic                ready_MEM_L2;
  logic [511:0]        read_data_MEM_L2;

  l2_mem_arbiter #(.TNUM(TNUM), .INUM(INUM)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .read_req          (read_req),
    .write_req         (write_req),
    .tag_req           (tag_req),
    .index_req         (index_req),
    .wdata_req         (wdata_req),
    .ready_req         (ready_req),
    .rdata_req         (rdata_req),
    .busy              (busy),
    .read_L2_MEM       (read_L2_MEM),
    .write_L2_MEM      (write_L2_MEM),
    .tag_L2_MEM        (tag_L2_MEM),
    .index_L2_MEM      (index_L2_MEM),
    .write_data_L2_MEM (write_data_L2_MEM),
    .ready_MEM_L2      (ready_MEM_L2),
    .read_data_MEM_L2  (read_data_MEM_L2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned     r;
    bit              wr;
    logic [TNUM-1:0] tag;
    logic [INUM-1:0] idx;
    logic [511:0]    wdata;
  } exp_t;

  typedef struct {
    int unsigned     r;
    bit              rd;
    bit              wr;
    logic [TNUM-1:0] tag;
    logic [INUM-1:0] idx;
    logic [511:0]    wdata;
    int unsigned     lat;
    logic [511:0]    mem;
  } vec_t;

  exp_t         sb_q[$];
  vec_t         vecs[5];
  int           checks = 0;
  int           errors = 0;
  logic [511:0] exp_rdata = '0;
  bit           model_last = 1'b1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int unsigned r, input bit rd, input bit wr,
                         input logic [TNUM-1:0] tag, input logic [INUM-1:0] idx,
                         input logic [511:0] wd, input bit push);
    exp_t e;
    read_req[r]                = rd;
    write_req[r]               = wr;
    tag_req[r*TNUM +: TNUM]    = tag;
    index_req[r*INUM +: INUM]  = idx;
    wdata_req[r*512 +: 512]    = wd;
    if (push && (rd || wr)) begin
      e.r = r; e.wr = wr; e.tag = tag; e.idx = idx; e.wdata = wd;
      sb_q.push_back(e);
    end
  endtask

  // Both requesters read at once; expected order follows the bench's own round-robin model.
  task automatic set_pair(input logic [TNUM-1:0] t0, input logic [TNUM-1:0] t1);
    exp_t e0, e1;
    set_req(0, 1'b1, 1'b0, t0, 5'h01, '0, 1'b0);
    set_req(1, 1'b1, 1'b0, t1, 5'h02, '0, 1'b0);
    e0.r = 0; e0.wr = 1'b0; e0.tag = t0; e0.idx = 5'h01; e0.wdata = '0;
    e1.r = 1; e1.wr = 1'b0; e1.tag = t1; e1.idx = 5'h02; e1.wdata = '0;
    if (model_last) begin
      sb_q.push_back(e0); sb_q.push_back(e1);
    end else begin
      sb_q.push_back(e1); sb_q.push_back(e0);
    end
  endtask

  // Play memory for the next expected transaction: hold lat cycles, then complete.
  task automatic serve(input int unsigned lat, input logic [511:0] mem_data, input bit scramble);
    exp_t e;
    int   waitc = 0;
    bit   held_ok = 1'b1;
    e = sb_q.pop_front();
    while (!(read_L2_MEM || write_L2_MEM) && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 20) begin
      checks++;
      errors++;
      $display("FAIL cmd_timeout: got no command expected one for requester %0d", e.r);
      return;
    end
    chk("op_write", write_L2_MEM, e.wr);
    chk("op_read", read_L2_MEM, !e.wr);
    chk("tag", tag_L2_MEM, e.tag);
    chk("index", index_L2_MEM, e.idx);
    if (e.wr) chk("wdata", write_data_L2_MEM, e.wdata);
    for (int i = 1; i <= int'(lat); i++) begin
      if (!(read_L2_MEM == !e.wr && write_L2_MEM == e.wr && tag_L2_MEM == e.tag &&
            index_L2_MEM == e.idx && busy && ready_req == 2'b00 &&
            (!e.wr || write_data_L2_MEM == e.wdata)))
        held_ok = 1'b0;
      if (i == 1 && scramble) begin
        tag_req          = ~tag_req;
        index_req        = ~index_req;
        wdata_req        = ~wdata_req;
        read_req[e.r]    = 1'b0;
        write_req[e.r]   = 1'b0;
      end
      if (i == int'(lat)) begin
        ready_MEM_L2     = 1'b1;
        read_data_MEM_L2 = mem_data;
      end
      @(negedge clk);
    end
    ready_MEM_L2     = 1'b0;
    read_data_MEM_L2 = ~mem_data;
    chk("cmd_held", held_ok, 1'b1);
    chk("ready_pulse", ready_req, 2'b01 << e.r);
    chk("cmd_off", {read_L2_MEM, write_L2_MEM}, 2'b00);
    chk("busy_done", busy, 1'b1);
    if (!e.wr) exp_rdata = mem_data;
    chk("rdata", rdata_req, exp_rdata);
    model_last     = e.r[0];
    read_req[e.r]  = 1'b0;
    write_req[e.r] = 1'b0;
    @(negedge clk);
    chk("ready_once", ready_req, 2'b00);
    chk("busy_idle", busy, 1'b0);
    chk("rdata_hold", rdata_req, exp_rdata);
  endtask

  initial begin
    int   waitc;
    logic [1:0] rr_seen;
    rstn = 1'b0;
    read_req = '0; write_req = '0; tag_req = '0; index_req = '0; wdata_req = '0;
    ready_MEM_L2 = 1'b0; read_data_MEM_L2 = '0;

    vecs[0] = '{r: 0, rd: 1, wr: 0, tag: 21'h1, idx: 5'h3, wdata: '0, lat: 5,
                mem: {64{8'hA5}}};
    vecs[1] = '{r: 1, rd: 1, wr: 1, tag: 21'h12345, idx: 5'h11, wdata: {64{8'h5A}}, lat: 3,
                mem: {64{8'h77}}};
    vecs[2] = '{r: 1, rd: 1, wr: 0, tag: 21'h1FFFFF, idx: 5'h1F, wdata: '0, lat: 1,
                mem: {16{32'h12345678}}};
    vecs[3] = '{r: 0, rd: 0, wr: 1, tag: 21'h0AAAA, idx: 5'h0A, wdata: {16{32'hDEADBEEF}},
                lat: 2, mem: {64{8'h3C}}};
    vecs[4] = '{r: 0, rd: 1, wr: 0, tag: 21'h15555, idx: 5'h15, wdata: '0, lat: 4,
                mem: {512{1'b1}}};

    // Reset state
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd", {read_L2_MEM, write_L2_MEM}, 2'b00);
    chk("rst_ready", ready_req, 2'b00);
    chk("rst_rdata", rdata_req, '0);
    chk("rst_tag", tag_L2_MEM, '0);
    rstn = 1'b1;
    @(negedge clk);

    // First tie after reset goes to requester 0, then 1; repeat gives the same order.
    set_pair(21'h00100, 21'h00200);
    serve(2, {16{32'h0000_1111}}, 1'b0);
    serve(2, {16{32'h0000_2222}}, 1'b0);
    set_pair(21'h00300, 21'h00400);
    serve(1, {16{32'h0000_3333}}, 1'b0);
    serve(3, {16{32'h0000_4444}}, 1'b0);

    // Single-requester transactions
    for (int i = 0; i < 5; i++) begin
      set_req(vecs[i].r, vecs[i].rd, vecs[i].wr, vecs[i].tag, vecs[i].idx, vecs[i].wdata, 1'b1);
      serve(vecs[i].lat, vecs[i].mem, 1'b0);
    end

    // Inputs changed and request withdrawn mid-BUSY: latched values must stay.
    set_req(0, 1'b0, 1'b1, 21'h0F0F0, 5'h0C, {8{64'h0123_4567_89AB_CDEF}}, 1'b1);
    serve(4, {64{8'h99}}, 1'b1);
    tag_req = '0; index_req = '0; wdata_req = '0;

    // Memory ready while idle is ignored.
    ready_MEM_L2 = 1'b1;
    read_data_MEM_L2 = {64{8'hEE}};
    @(negedge clk);
    ready_MEM_L2 = 1'b0;
    chk("idle_ready_pulse", ready_req, 2'b00);
    chk("idle_ready_busy", busy, 1'b0);
    @(negedge clk);
    chk("idle_ready_rdata", rdata_req, exp_rdata);

    // Reset during BUSY: outputs drop at once, no ready pulse, next tie to requester 0.
    set_req(1, 1'b1, 1'b0, 21'h0BEEF, 5'h07, '0, 1'b0);
    waitc = 0;
    while (!read_L2_MEM && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk("rst_busy_cmd_seen", read_L2_MEM, 1'b1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_cmd", {read_L2_MEM, write_L2_MEM}, 2'b00);
    chk("rst_mid_ready", ready_req, 2'b00);
    chk("rst_mid_rdata", rdata_req, '0);
    chk("rst_mid_tag", tag_L2_MEM, '0);
    chk("rst_mid_index", index_L2_MEM, '0);
    exp_rdata  = '0;
    model_last = 1'b1;
    read_req = '0; write_req = '0;
    @(negedge clk);
    rstn = 1'b1;
    rr_seen = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rr_seen = rr_seen | ready_req;
    end
    chk("rst_no_ready", rr_seen, 2'b00);
    set_pair(21'h00500, 21'h00600);
    serve(2, {16{32'h0000_5555}}, 1'b0);
    serve(1, {16{32'h0000_6666}}, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l2_mem_arbiter.md
L2_MEM_ARBITER -- requirements
Module: l2_mem_arbiter

Interface
REQ-001 The block SHALL have parameter TNUM, default 21, tag width in bits.
REQ-002 The block SHALL have parameter INUM, default 26-TNUM, index width in bits.
REQ-003 The block SHALL have port clk  input  1  sole clock, all state on its rising edge.
REQ-004 The block SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port read_req  input  2  per-requester read request, bit r = requester r.
REQ-006 The block SHALL have port write_req  input  2  per-requester write request.
REQ-007 The block SHALL have port tag_req  input  2*TNUM  tags; requester r at [r*TNUM +: TNUM].
REQ-008 The block SHALL have port index_req  input  2*INUM  indices; requester r at [r*INUM +: INUM].
REQ-009 The block SHALL have port wdata_req  input  1024  write lines; requester r at [r*512 +: 512].
REQ-010 The block SHALL have port ready_req  output  2  one-cycle completion pulse to requester r.
REQ-011 The block SHALL have port rdata_req  output  512  read line, shared by both requesters.
REQ-012 The block SHALL have port busy  output  1  high while a transaction is owned.
REQ-013 The block SHALL have ports read_L2_MEM, write_L2_MEM  output  1 each  memory commands.
REQ-014 The block SHALL have ports tag_L2_MEM (TNUM), index_L2_MEM (INUM), write_data_L2_MEM (512)  output  memory address and data.
REQ-015 The block SHALL have ports ready_MEM_L2  input  1 and read_data_MEM_L2  input  512  memory completion and line.

Function
REQ-016 FSM states SHALL be IDLE, BUSY and DONE.
REQ-017 IDLE: a requester is pending when its read_req or write_req is high.
REQ-018 IDLE with one pending requester: grant it, go to BUSY next cycle.
REQ-019 IDLE with both pending: grant the requester not granted last (round-robin); last_grant SHALL reset to 1, so requester 0 wins the first tie.
REQ-020 On grant, the block SHALL latch the granted op, tag, index and wdata; later changes to requester inputs SHALL be ignored until DONE.
REQ-021 Granted requester with read and write both high: treated as a write.
REQ-022 BUSY: drive exactly one of read_L2_MEM/write_L2_MEM plus the latched tag, index and data, held constant until ready_MEM_L2=1; both commands never high together.
REQ-023 Request seen in IDLE at cycle N: memory command first high at cycle N+1.
REQ-024 ready_MEM_L2 high in BUSY at cycle M: commands low from M+1, ready_req[grant] high for exactly cycle M+1, state DONE at M+1, IDLE at M+2.
REQ-025 On a read completion, rdata_req SHALL load read_data_MEM_L2 and be valid from M+1, held until the next read completion; write completions leave rdata_req unchanged.
REQ-026 DONE SHALL grant nothing, so the requester can drop its request on seeing ready_req.
REQ-027 ready_MEM_L2 in IDLE or DONE SHALL be ignored.
REQ-028 busy SHALL be high in BUSY and DONE, low in IDLE.
REQ-029 A request withdrawn while BUSY SHALL NOT abort the transaction.

Reset
REQ-030 rstn low SHALL immediately force IDLE, last_grant=1, and all outputs to 0, including rdata_req and the latched registers.
REQ-031 Reset during BUSY SHALL drop the memory command with no ready_req pulse; requesters reissue.

Verification
REQ-032 Requester 0 reads tag=0x1, index=0x3; memory ready 5 cycles later with 0xA5..A5 -> read_L2_MEM held 5 cycles, ready_req=01 for one cycle, rdata_req=0xA5..A5.
REQ-033 Both read_req bits set at cycle 0 from reset -> requester 0 served first, requester 1 second; repeat with both set -> order 0 then 1 again.
REQ-034 Requester 1 sets read_req and write_req with wdata=0x5A..5A -> only write_L2_MEM asserts, write_data_L2_MEM=0x5A..5A, rdata_req unchanged.
REQ-035 Requester changes tag and index mid-BUSY -> tag_L2_MEM and index_L2_MEM keep the latched values until completion.
REQ-036 rstn pulsed low during BUSY -> outputs 0 the same cycle, no ready_req pulse, next tie goes to requester 0.
